// File: rtl/ysyx_22050550_wb_arbiter_if.sv
// Register-file write-port bus shared by the writeback stream, the MDU
// and the registered register-file write. The arbiter uses the slave
// modport. The master modport is the view seen by requesters and RF.
interface ysyx_22050550_wb_arbiter_if;
  // Writeback request
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  // MDU result
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [63:0] mdu_wdata;
  // Registered register-file write
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_owner;

  modport slave (
    input  wb_valid, wb_wen, wb_waddr, wb_wdata,
    input  mdu_valid, mdu_waddr, mdu_wdata,
    output wb_ready, mdu_ready,
    output rf_wen, rf_waddr, rf_wdata, rf_owner
  );

  modport master (
    output wb_valid, wb_wen, wb_waddr, wb_wdata,
    output mdu_valid, mdu_waddr, mdu_wdata,
    input  wb_ready, mdu_ready,
    input  rf_wen, rf_waddr, rf_wdata, rf_owner
  );
endinterface

// File: rtl/ysyx_22050550_wb_arbiter.sv
// Register-file write-port arbiter.
// The writeback stream and the MDU share one 64-bit RF write port.
// Writeback has default priority. The winning request is registered for
// one cycle onto rf_*.
// Optional feature macro: YSYX_22050550_WBARB_STARVE_EN.
//   - Defined: a starvation counter forces MDU priority after
//     STARVE_LIMIT consecutive blocked cycles.
//   - Not defined: fixed priority, and writeback always wins.
module ysyx_22050550_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic                     clock,
  input logic                     reset,
  ysyx_22050550_wb_arbiter_if.slave bus
);

  // Reject limits that the counter cannot represent.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("STARVE_LIMIT must be in 1..2**CNT_W-1");
  end

  logic wb_grant;
  logic mdu_grant;

`ifdef YSYX_22050550_WBARB_STARVE_EN
  typedef enum logic {
    PRIO_WB  = 1'b0,
    PRIO_MDU = 1'b1
  } prio_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  prio_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Grant from the current priority state; MDU wins only when it holds priority or WB is idle.
  always_comb begin
    mdu_grant = bus.mdu_valid & (~bus.wb_valid | (state_q == PRIO_MDU));
    wb_grant  = bus.wb_valid & ~mdu_grant;
  end

  // Starvation counter and priority next-state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d   = '0;
    state_d = state_q;
    if (bus.mdu_valid && !mdu_grant) begin
      cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      PRIO_WB:  if (cnt_d == LIMIT) state_d = PRIO_MDU;
      PRIO_MDU: if (!bus.mdu_valid || mdu_grant) state_d = PRIO_WB;
      default:  state_d = PRIO_WB;
    endcase
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PRIO_WB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Fixed priority: the MDU is served only in cycles when writeback is idle.
  always_comb begin
    wb_grant  = bus.wb_valid;
    mdu_grant = bus.mdu_valid & ~bus.wb_valid;
  end
`endif

  assign bus.wb_ready  = wb_grant;
  assign bus.mdu_ready = mdu_grant;

  logic        rf_wen_q,   rf_wen_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [63:0] rf_wdata_q, rf_wdata_d;
  logic        rf_owner_q, rf_owner_d;

  // Next RF write: latch the winner's payload, and suppress the enable for x0.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_owner_d = rf_owner_q;
    if (wb_grant) begin
      rf_wen_d   = bus.wb_wen & (bus.wb_waddr != 5'd0);
      rf_waddr_d = bus.wb_waddr;
      rf_wdata_d = bus.wb_wdata;
      rf_owner_d = 1'b0;
    end else if (mdu_grant) begin
      rf_wen_d   = (bus.mdu_waddr != 5'd0);
      rf_waddr_d = bus.mdu_waddr;
      rf_wdata_d = bus.mdu_wdata;
      rf_owner_d = 1'b1;
    end
  end

  // Output register loads every cycle; reset drops any pending write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_owner_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_owner_q <= rf_owner_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.rf_owner = rf_owner_q;

endmodule

// File: doc/ysyx_22050550_wb_arbiter.md
# ysyx_22050550_wb_arbiter

Register-file write-port arbiter sitting between the writeback stage and the general register file. It shares the single 64-bit write port between the in-order writeback stream and the multi-cycle multiply/divide unit (MDU), registers the winning write for one cycle, and guarantees MDU forward progress with a starvation counter. Writeback stays the default-priority requester so the in-order pipeline is not throttled in normal operation.

## Interface
- STARVE_LIMIT, 4, consecutive MDU-blocked cycles before MDU gets forced priority (1..2^CNT_W-1)
- CNT_W, 3, starvation counter width
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wb_valid  input  1  writeback request valid
- wb_ready  output  1  writeback request accepted this cycle
- wb_wen  input  1  writeback intends a register write
- wb_waddr  input  5  writeback destination register
- wb_wdata  input  64  writeback data
- mdu_valid  input  1  MDU result valid
- mdu_ready  output  1  MDU result accepted this cycle
- mdu_waddr  input  5  MDU destination register
- mdu_wdata  input  64  MDU result data
- rf_wen  output  1  registered register-file write enable
- rf_waddr  output  5  registered write address
- rf_wdata  output  64  registered write data
- rf_owner  output  1  registered source of current write: 0 writeback, 1 MDU

## Operation
- Priority state PRIO_WB (reset) / PRIO_MDU.
- Grant is combinational from current state and valids:
  - PRIO_WB: wb_valid wins; else mdu_valid wins.
  - PRIO_MDU: mdu_valid wins; else wb_valid wins.
- wb_ready / mdu_ready high only for the granted requester; never both high. Transfer = valid & ready.
- Requesters hold valid and payload stable until transfer; arbiter does not buffer unaccepted requests.
- Output register always loads: on transfer, rf_waddr/rf_wdata/rf_owner take the winner's payload; rf_wen = winner wen (MDU wen implicitly 1) AND waddr != 0. No transfer: rf_wen = 0, addr/data/owner hold.
- Writes to x0 are accepted (ready asserted) but produce rf_wen = 0.
- Starvation counter: increments (saturating at STARVE_LIMIT) each cycle mdu_valid & !mdu_ready; clears on MDU transfer or when mdu_valid is low.
- Transitions: PRIO_WB -> PRIO_MDU when counter reaches STARVE_LIMIT; PRIO_MDU -> PRIO_WB on MDU transfer or mdu_valid low.
- Same-rd writes from both sources are committed in grant order; no merging.

## Timing
- Reset (reset low, asynchronous): rf_wen 0, rf_waddr 0, rf_wdata 0, rf_owner 0, counter 0, state PRIO_WB. Ready outputs are combinational and follow valids immediately after reset release.
- Latency: accepted request appears on rf_* exactly 1 cycle after the transfer edge; throughput one write per cycle.
- rf_wen is a single-cycle pulse per transfer.
- Reset asserted mid-operation drops the registered write (rf_wen forced 0); requesters re-present after release.
- With STARVE_LIMIT = N and continuous wb_valid, MDU is granted in the (N+1)th cycle of its wait.

## Configuration
- YSYX_22050550_WBARB_STARVE_EN defined: starvation counter and PRIO_MDU state compiled in as above.
- Not defined: counter and state removed; fixed priority, writeback always wins; MDU granted only in cycles with wb_valid low.

## Test plan
- Reset then wb_valid=1, wb_waddr=5, wb_wdata=0x1234, wen=1 -> wb_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, rf_owner=0.
- Both valid, MDU rd=7 data=0xAA, wb held valid continuously, STARVE_LIMIT=4, macro on -> wb granted cycles 0-3, MDU granted cycle 4, rf_owner=1, rf_waddr=7 in cycle 5; wb granted again cycle 5.
- Same stimulus, macro off -> MDU never granted while wb_valid=1; granted first cycle wb_valid drops.
- wb_valid=1, wb_waddr=0, wen=1 -> wb_ready=1, next cycle rf_wen=0; wb_wen=0 with waddr=3 -> rf_wen=0.
- reset driven low between transfer edge and next edge -> rf_wen=0, rf_wdata=0 immediately, counter cleared, state PRIO_WB.
- Alternating MDU-only and wb-only valid cycles -> each granted same cycle, back-to-back rf_wen pulses, no gaps, counter stays 0.
